// File: rtl/perf_count_sampler.sv
// Avalon-MM master sequencing start/stop/clear commands and tear-free reads of the
// perf-count control slave (no waitrequest, readdata registered one cycle behind address).
module perf_count_sampler #(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        start_req,
    input  logic        stop_req,
    input  logic        clear_req,
    input  logic        read_req,
    output logic        busy,
    output logic        result_valid,
    output logic [63:0] time_count,
    output logic [31:0] event_count,
    output logic        torn,
    output logic [2:0]  m_address,
    output logic        m_begintransfer,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata
);

    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRdHi1,
        StRdLo,
        StRdHi2,
        StRdEvt,
        StCheck
    } state_e;

    state_e      state_q;
    logic        base_q;
    logic [2:0]  retry_q;
    logic [31:0] hi1_q;
    logic [31:0] lo_q;
    logic [31:0] hi2_q;

    // Bus outputs are set on entry to a state, so each state's cycle shows its own address
    // while m_readdata carries the word addressed by the previous state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            base_q          <= 1'b0;
            retry_q         <= '0;
            hi1_q           <= '0;
            lo_q            <= '0;
            hi2_q           <= '0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            time_count      <= '0;
            event_count     <= '0;
            torn            <= 1'b0;
            m_address       <= '0;
            m_begintransfer <= 1'b0;
            m_write         <= 1'b0;
            m_writedata     <= '0;
        end else begin
            result_valid    <= 1'b0;
            m_begintransfer <= 1'b0;
            m_write         <= 1'b0;
            m_writedata     <= '0;
            case (state_q)
                StIdle: begin
                    if (clear_req) begin
                        state_q         <= StCmd;
                        busy            <= 1'b1;
                        base_q          <= sel;
                        m_address       <= 3'd0;
                        m_writedata     <= 32'd1;
                        m_write         <= 1'b1;
                        m_begintransfer <= 1'b1;
                    end else if (stop_req) begin
                        state_q         <= StCmd;
                        busy            <= 1'b1;
                        base_q          <= sel;
                        m_address       <= {sel, 2'd0};
                        m_write         <= 1'b1;
                        m_begintransfer <= 1'b1;
                    end else if (start_req) begin
                        state_q         <= StCmd;
                        busy            <= 1'b1;
                        base_q          <= sel;
                        m_address       <= {sel, 2'd1};
                        m_write         <= 1'b1;
                        m_begintransfer <= 1'b1;
                    end else if (read_req) begin
                        state_q         <= StRdHi1;
                        busy            <= 1'b1;
                        base_q          <= sel;
                        retry_q         <= '0;
                        m_address       <= {sel, 2'd1};
                        m_begintransfer <= 1'b1;
                    end
                end
                StCmd: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                StRdHi1: begin
                    state_q         <= StRdLo;
                    m_address       <= {base_q, 2'd0};
                    m_begintransfer <= 1'b1;
                end
                StRdLo: begin
                    hi1_q           <= m_readdata;
                    state_q         <= StRdHi2;
                    m_address       <= {base_q, 2'd1};
                    m_begintransfer <= 1'b1;
                end
                StRdHi2: begin
                    lo_q            <= m_readdata;
                    state_q         <= StRdEvt;
                    m_address       <= {base_q, 2'd2};
                    m_begintransfer <= 1'b1;
                end
                StRdEvt: begin
                    hi2_q   <= m_readdata;
                    state_q <= StCheck;
                end
                StCheck: begin
                    // Equal high words bracket the low word, so {hi2, lo} cannot be torn.
                    if (hi1_q == hi2_q || retry_q == MaxRetry) begin
                        state_q      <= StIdle;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        time_count   <= {hi2_q, lo_q};
                        event_count  <= m_readdata;
                        torn         <= (hi1_q != hi2_q);
                    end else begin
                        retry_q         <= retry_q + 3'd1;
                        state_q         <= StRdHi1;
                        m_address       <= {base_q, 2'd1};
                        m_begintransfer <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_count_sampler.sv
// Directed bench for perf_count_sampler: behavioural perf-count slave plus a second
// instance with MAX_RETRY=0 fed by a slave whose high word changes on every read.
module tb_perf_count_sampler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel, start_req, stop_req, clear_req, read_req;
    logic        busy, result_valid, torn;
    logic [63:0] time_count;
    logic [31:0] event_count;
    logic [2:0]  m_address;
    logic        m_begintransfer, m_write;
    logic [31:0] m_writedata, m_readdata;

    logic        read_req0;
    logic        busy0, result_valid0, torn0;
    logic [63:0] time_count0;
    logic [31:0] event_count0;
    logic [2:0]  m_address0;
    logic        m_begintransfer0, m_write0;
    logic [31:0] m_writedata0, m_readdata0;

    int total = 0;
    int passed = 0;
    int nfail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perf_count_sampler #(.MAX_RETRY(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .start_req(start_req),
        .stop_req(stop_req), .clear_req(clear_req), .read_req(read_req),
        .busy(busy), .result_valid(result_valid), .time_count(time_count),
        .event_count(event_count), .torn(torn), .m_address(m_address),
        .m_begintransfer(m_begintransfer), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    perf_count_sampler #(.MAX_RETRY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .sel(1'b0), .start_req(1'b0),
        .stop_req(1'b0), .clear_req(1'b0), .read_req(read_req0),
        .busy(busy0), .result_valid(result_valid0), .time_count(time_count0),
        .event_count(event_count0), .torn(torn0), .m_address(m_address0),
        .m_begintransfer(m_begintransfer0), .m_write(m_write0),
        .m_writedata(m_writedata0), .m_readdata(m_readdata0)
    );

    // Slave model: two sections, registered readdata, optional forced high-word sequence.
    logic [63:0] tm [2];
    logic [31:0] ev [2];
    logic        run [2];
    logic        tear_mode;
    logic [31:0] tear_hi [4];
    int          tear_idx;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                tm[s]  <= '0;
                ev[s]  <= '0;
                run[s] <= 1'b0;
            end
            tear_idx   <= 0;
            m_readdata <= '0;
        end else begin
            for (int s = 0; s < 2; s++) if (run[s]) tm[s] <= tm[s] + 64'd1;
            if (m_begintransfer && m_write) begin
                if (m_address == 3'd0 && m_writedata[0]) begin
                    tm[0] <= '0; tm[1] <= '0; ev[0] <= '0; ev[1] <= '0;
                end else if (m_address[1:0] == 2'd0) begin
                    run[m_address[2]] <= 1'b0;
                end else if (m_address[1:0] == 2'd1) begin
                    run[m_address[2]] <= 1'b1;
                    ev[m_address[2]]  <= ev[m_address[2]] + 32'd1;
                end
            end
            case (m_address[1:0])
                2'd0: m_readdata <= tm[m_address[2]][31:0];
                2'd1: begin
                    if (tear_mode && m_begintransfer && !m_write) begin
                        m_readdata <= tear_hi[tear_idx];
                        tear_idx   <= tear_idx + 1;
                    end else begin
                        m_readdata <= tm[m_address[2]][63:32];
                    end
                end
                2'd2: m_readdata <= ev[m_address[2]];
                default: m_readdata <= '0;
            endcase
        end
    end

    // Second slave: high word increments on every high read, everything else reads 0x55.
    logic [31:0] hi_cnt0;
    always @(posedge clk) begin
        if (!reset_n) begin
            hi_cnt0     <= '0;
            m_readdata0 <= '0;
        end else if (m_address0[1:0] == 2'd1 && m_begintransfer0) begin
            m_readdata0 <= hi_cnt0;
            hi_cnt0     <= hi_cnt0 + 32'd1;
        end else begin
            m_readdata0 <= 32'h0000_0055;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle request pulse; returns the cycle index at which it was driven.
    task automatic req(input logic s, input logic st, input logic sp, input logic cl,
                       input logic rd, output int c0);
        sel = s; start_req = st; stop_req = sp; clear_req = cl; read_req = rd;
        c0 = cyc;
        tick();
        start_req = 1'b0; stop_req = 1'b0; clear_req = 1'b0; read_req = 1'b0;
    endtask

    task automatic wait_rv(input bit which, input int c0, input int lim, output int lat);
        lat = -1;
        for (int i = 0; i < lim && lat < 0; i++) begin
            if ((which ? result_valid0 : result_valid) == 1'b1) lat = cyc - c0;
            else tick();
        end
    endtask

    initial begin
        int c0;
        int lat;
        logic seen;

        reset_n = 1'b0;
        sel = 1'b0; start_req = 1'b0; stop_req = 1'b0; clear_req = 1'b0; read_req = 1'b0;
        read_req0 = 1'b0;
        tear_mode = 1'b0;
        tear_hi[0] = 32'd0; tear_hi[1] = 32'd1; tear_hi[2] = 32'd1; tear_hi[3] = 32'd1;

        // Reset state
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rv", 64'(result_valid), 64'd0);
        check("rst_time", time_count, 64'd0);
        check("rst_event", 64'(event_count), 64'd0);
        check("rst_torn", 64'(torn), 64'd0);
        check("rst_addr", 64'(m_address), 64'd0);
        check("rst_bt", 64'(m_begintransfer), 64'd0);
        check("rst_write", 64'(m_write), 64'd0);
        check("rst_wdata", 64'(m_writedata), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Start on section 1
        req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c0);
        check("start1_addr", 64'(m_address), 64'd5);
        check("start1_write", 64'(m_write), 64'd1);
        check("start1_bt", 64'(m_begintransfer), 64'd1);
        check("start1_wdata", 64'(m_writedata), 64'd0);
        check("start1_busy", 64'(busy), 64'd1);
        tick();
        check("start1_busy_n2", 64'(busy), 64'd0);
        check("start1_bt_n2", 64'(m_begintransfer), 64'd0);
        check("start1_ev1", 64'(ev[1]), 64'd1);

        // Start section 0, 100 idle cycles, stop, read: 101 counted cycles
        req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c0);
        repeat (100) tick();
        req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0);
        check("stop0_addr", 64'(m_address), 64'd0);
        check("stop0_wdata", 64'(m_writedata), 64'd0);
        tick();
        req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        check("rd_busy", 64'(busy), 64'd1);
        check("rd_addr_n1", 64'(m_address), 64'd1);
        wait_rv(1'b0, c0, 30, lat);
        check("rd_latency", 64'(lat), 64'd6);
        check("rd_busy_done", 64'(busy), 64'd0);
        check("rd_event", 64'(event_count), 64'd1);
        check("rd_time_range", 64'(time_count >= 64'd100 && time_count <= 64'd102), 64'd1);
        check("rd_torn", 64'(torn), 64'd0);

        // Torn high word on the first pass, consistent on the second
        tear_mode = 1'b1;
        tick();
        req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        wait_rv(1'b0, c0, 40, lat);
        check("tear_latency", 64'(lat), 64'd11);
        check("tear_hi", 64'(time_count[63:32]), 64'd1);
        check("tear_lo", 64'(time_count[31:0]), 64'd101);
        check("tear_torn", 64'(torn), 64'd0);
        tear_mode = 1'b0;
        repeat (3) tick();
        check("hold_time", time_count, 64'h0000_0001_0000_0065);
        check("hold_rv", 64'(result_valid), 64'd0);

        // Asynchronous reset during a write cycle
        req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c0);
        check("pre_rst_write", 64'(m_write), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_write", 64'(m_write), 64'd0);
        check("arst_bt", 64'(m_begintransfer), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_addr", 64'(m_address), 64'd0);
        check("arst_time", time_count, 64'd0);
        check("arst_event", 64'(event_count), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_begintransfer || result_valid || busy) seen = 1'b1;
        end
        check("arst_no_resume", 64'(seen), 64'd0);

        // Give section 0 a nonzero state, then clear+stop+start together on sel=1
        req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c0);
        repeat (5) tick();
        req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c0);
        tick();
        req(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, c0);
        check("clr_addr", 64'(m_address), 64'd0);
        check("clr_wdata", 64'(m_writedata), 64'd1);
        check("clr_write", 64'(m_write), 64'd1);
        read_req = 1'b1;
        tick();
        read_req = 1'b0;
        check("clr_drop_bt", 64'(m_begintransfer), 64'd0);
        check("clr_drop_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_begintransfer || result_valid) seen = 1'b1;
        end
        check("clr_drop_quiet", 64'(seen), 64'd0);
        check("clr_no_start", 64'(ev[1]), 64'd0);
        check("clr_no_run1", 64'(run[1]), 64'd0);
        req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        wait_rv(1'b0, c0, 30, lat);
        check("clr_rd_latency", 64'(lat), 64'd6);
        check("clr_rd_time", time_count, 64'd0);
        check("clr_rd_event", 64'(event_count), 64'd0);

        // MAX_RETRY=0 with mismatching high words
        c0 = cyc;
        read_req0 = 1'b1;
        tick();
        read_req0 = 1'b0;
        wait_rv(1'b1, c0, 30, lat);
        check("r0_latency", 64'(lat), 64'd6);
        check("r0_torn", 64'(torn0), 64'd1);
        check("r0_time", time_count0, 64'h0000_0001_0000_0055);
        check("r0_event", 64'(event_count0), 64'h55);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/perf_count_sampler.md
# perf_count_sampler

Avalon-MM master that drives the control slave of the coprocessor performance counter (8-word, two-section counter, no waitrequest, registered readdata). It turns single-cycle start, stop, clear and read requests from coprocessor logic into correctly sequenced bus cycles. It returns a tear-free 64-bit time count and a 32-bit event count for the selected section. It sits beside the perf-count slave in the coprocessor subsystem and replaces software polling of the counters.

## Interface
- MAX_RETRY, default 3: maximum re-reads after a torn 64-bit time sample (legal range 0..7).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sel  in  1  section select, sampled with any request (0: word base 0, 1: word base 4).
- start_req  in  1  single-cycle pulse: start the time counter and count one event.
- stop_req  in  1  single-cycle pulse: stop the time counter.
- clear_req  in  1  single-cycle pulse: global clear of all counters in both sections.
- read_req  in  1  single-cycle pulse: sample time and event counts.
- busy  out  1  high while a sequence is in progress; requests are dropped while high.
- result_valid  out  1  one-cycle pulse when time_count/event_count/torn are updated.
- time_count  out  64  sampled time counter.
- event_count  out  32  sampled event counter.
- torn  out  1  set with result_valid when the retry budget ran out with high words still mismatching.
- m_address  out  3  Avalon word address to the slave.
- m_begintransfer  out  1  high for every bus cycle issued (read or write).
- m_write  out  1  write strobe.
- m_writedata  out  32  write data.
- m_readdata  in  32  slave readdata; reflects the address presented in the previous cycle.

## Operation
- All bus outputs are registered. Each bus cycle lasts exactly 1 clk because the slave has no waitrequest.
- Reset values: all outputs 0; state IDLE; retry counter 0; captured words 0.
- Request acceptance: only in IDLE, with busy=0. Priority when several requests are high together: clear > stop > start > read. Requests that are not accepted are dropped, not queued. sel is latched at acceptance as base B = sel ? 4 : 0.
- Address map driven for a section with base B:
  - B+0: write data bit0=0 stops the section; read returns time[31:0].
  - B+1: write starts the section and counts one event; read returns time[63:32].
  - B+2: read returns the event count.
  - Write address 0 with data 1: global clear.
- States:
  - IDLE: no bus cycle.
  - CMD: one write cycle, then IDLE.
    - start: address B+1, data 0.
    - stop: address B+0, data 0.
    - clear: address 0, data 1, regardless of sel.
  - RD_HI1: read address B+1.
  - RD_LO: read address B+0; capture hi1 from readdata.
  - RD_HI2: read address B+1; capture lo.
  - RD_EVT: read address B+2; capture hi2.
  - CHECK: no bus cycle; capture evt.
    - If hi1==hi2, or the retry counter equals MAX_RETRY: go to IDLE and present results.
    - Otherwise increment the retry counter and go to RD_HI1.
- Result assembly:
  - time_count = {hi2, lo}.
  - event_count = evt.
  - torn = (hi1 != hi2).
  - The retry counter clears when a read request is accepted.
- While no bus cycle is issued: m_begintransfer=0, m_write=0, m_address holds its last value, m_writedata=0.

## Timing
- Request sampled high in cycle N: busy=1 from N+1.
- Command: write is on the bus in N+1; busy=0 and IDLE again in N+2. A new request is accepted in N+2.
- Read without retry:
  - Bus reads in N+1..N+4; CHECK in N+5.
  - result_valid=1 in N+6 with the outputs updated; busy=0 in N+6.
- Each retry adds 5 cycles. Worst-case latency is 6 + 5·MAX_RETRY cycles.
- time_count, event_count and torn hold their values between result_valid pulses.
- Asynchronous reset mid-sequence: all outputs return to their reset values immediately, including m_write=0. The in-flight sequence is abandoned and does not resume.

## Test plan
- Reset: assert reset_n=0 mid-run.
  - All outputs 0 within the reset.
  - No bus cycle until a new request arrives after release.
- start_req with sel=1 at cycle N:
  - N+1: m_address=5, m_write=1, m_begintransfer=1.
  - N+2: busy=0.
  - Slave event_counter_1 increments by 1.
- start, then 100 idle cycles, then stop, then read_req on sel=0: result_valid 6 cycles after read_req, with event_count=1, time_count=101±1 and torn=0.
- Tear: slave model returns hi=0 then hi=1 on the first pass, hi=1 on both reads of the second pass.
  - Retry occurs once; result_valid 11 cycles after read_req.
  - time_count[63:32]=1, torn=0.
- MAX_RETRY=0 with a mismatching hi: result_valid after 6 cycles with torn=1.
- clear_req, stop_req and start_req asserted together with sel=1:
  - Only the clear write is issued: address 0, data 1.
  - A read_req during busy is dropped.
  - A later read returns time_count=0 and event_count=0.
